// File: rtl/pipe_prefix_adder_if.sv
// Operand/result bus for pipe_prefix_adder: upstream valid/ready with the
// operands, downstream valid/ready with the result and flags.
interface pipe_prefix_adder_if #(
    parameter int WIDTH = 16
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             sub;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             ovf;

    // Producer of operands / consumer of results.
    modport master (
        output in_valid, a, b, cin, sub, out_ready,
        input  in_ready, out_valid, sum, cout, ovf
    );

    // The adder itself.
    modport slave (
        input  in_valid, a, b, cin, sub, out_ready,
        output in_ready, out_valid, sum, cout, ovf
    );
endinterface

// File: rtl/pipe_prefix_adder.sv
// Pipelined Kogge-Stone adder/subtractor built from KPG combine cells.
// Tree position 0 carries the effective carry-in (always K or G); position j
// (j >= 1) carries bit j-1, so after LEVELS levels position j holds the carry
// into bit j. The MSB's own generate travels alongside to form cout.
// One global advance enable freezes every stage while the result is stalled.
module pipe_prefix_adder #(
    parameter int WIDTH = 16,
    parameter bit PIPE  = 1'b1
) (
    input  logic               clk,
    input  logic               rst_n,
    pipe_prefix_adder_if.slave bus
);
    localparam int LEVELS = $clog2(WIDTH);

    logic             adv_s;
    logic             out_valid_q;
    logic [WIDTH-1:0] sum_q;
    logic             cout_q;
    logic             ovf_q;

    assign adv_s        = ~out_valid_q | bus.out_ready;
    assign bus.in_ready = adv_s;

    // ---------------- stage 0 ----------------
    logic [WIDTH-1:0] b_eff_s;
    logic             c0_s;
    logic [WIDTH-1:0] x0_d, g0_d, p0_d;
    logic             m0_d;
    logic [WIDTH-1:0] x0_q, g0_q, p0_q;
    logic             m0_q, v0_q;

    // Form b', the effective carry-in and the per-position KPG vectors.
    always_comb begin
        b_eff_s = bus.sub ? ~bus.b : bus.b;
        c0_s    = bus.sub | bus.cin;
        x0_d    = bus.a ^ b_eff_s;
        g0_d    = {bus.a[WIDTH-2:0] & b_eff_s[WIDTH-2:0], c0_s};
        p0_d    = {x0_d[WIDTH-2:0], 1'b0};
        m0_d    = bus.a[WIDTH-1] & b_eff_s[WIDTH-1];
    end

    // Input register: captures every beat slot (bubbles included) on advance.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v0_q <= 1'b0;
            x0_q <= '0;
            g0_q <= '0;
            p0_q <= '0;
            m0_q <= 1'b0;
        end else if (adv_s) begin
            v0_q <= bus.in_valid;
            x0_q <= x0_d;
            g0_q <= g0_d;
            p0_q <= p0_d;
            m0_q <= m0_d;
        end
    end

    // ---------------- prefix levels ----------------
    for (genvar k = 1; k <= LEVELS; k++) begin : g_level
        localparam int DIST = 1 << (k - 1);

        logic [WIDTH-1:0] g_in_s, p_in_s, x_in_s;
        logic             v_in_s, m_in_s;
        logic [WIDTH-1:0] g_d;
        logic [WIDTH-1:0] g_out_s, x_out_s;
        logic             v_out_s, m_out_s;

        if (k == 1) begin : g_src_first
            assign g_in_s = g0_q;
            assign p_in_s = p0_q;
            assign x_in_s = x0_q;
            assign v_in_s = v0_q;
            assign m_in_s = m0_q;
        end else begin : g_src_prev
            assign g_in_s = g_level[k-1].g_out_s;
            assign p_in_s = g_level[k-1].g_prop.p_out_s;
            assign x_in_s = g_level[k-1].x_out_s;
            assign v_in_s = g_level[k-1].v_out_s;
            assign m_in_s = g_level[k-1].m_out_s;
        end

        // Generate half of the combine: a propagating upper position takes the
        // lower one's value. Positions below DIST are already resolved (never
        // P), so treating their lower operand as kill leaves them unchanged.
        always_comb begin
            g_d = g_in_s;
            for (int j = 0; j < WIDTH; j++) begin
                if (j >= DIST) begin
                    g_d[j] = p_in_s[j] ? g_in_s[j-DIST] : g_in_s[j];
                end else begin
                    g_d[j] = p_in_s[j] ? 1'b0 : g_in_s[j];
                end
            end
        end

        // Propagate half is only needed by the levels that follow.
        if (k < LEVELS) begin : g_prop
            logic [WIDTH-1:0] p_d, p_out_s;

            // Stays P only if both upper and lower are P; low positions pass.
            always_comb begin
                p_d = p_in_s;
                for (int j = DIST; j < WIDTH; j++) begin
                    p_d[j] = p_in_s[j] & p_in_s[j-DIST];
                end
            end

            if (PIPE) begin : g_preg
                logic [WIDTH-1:0] p_q;
                // Level propagate register, frozen with the rest of the pipe.
                always_ff @(posedge clk or negedge rst_n) begin
                    if (!rst_n) begin
                        p_q <= '0;
                    end else if (adv_s) begin
                        p_q <= p_d;
                    end
                end
                assign p_out_s = p_q;
            end else begin : g_pbyp
                assign p_out_s = p_d;
            end
        end

        if (PIPE) begin : g_reg
            logic [WIDTH-1:0] g_q, x_q;
            logic             v_q, m_q;
            // Level register carrying generate, sum XOR, MSB generate and valid.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    v_q <= 1'b0;
                    g_q <= '0;
                    x_q <= '0;
                    m_q <= 1'b0;
                end else if (adv_s) begin
                    v_q <= v_in_s;
                    g_q <= g_d;
                    x_q <= x_in_s;
                    m_q <= m_in_s;
                end
            end
            assign g_out_s = g_q;
            assign x_out_s = x_q;
            assign v_out_s = v_q;
            assign m_out_s = m_q;
        end else begin : g_byp
            assign g_out_s = g_d;
            assign x_out_s = x_in_s;
            assign v_out_s = v_in_s;
            assign m_out_s = m_in_s;
        end
    end

    // ---------------- output stage ----------------
    logic [WIDTH-1:0] carry_s, xf_s, sum_d;
    logic             vf_s, mf_s, cout_d, ovf_d;

    assign carry_s = g_level[LEVELS].g_out_s;
    assign xf_s    = g_level[LEVELS].x_out_s;
    assign vf_s    = g_level[LEVELS].v_out_s;
    assign mf_s    = g_level[LEVELS].m_out_s;

    // Sum bits from resolved carries; cout folds the MSB's own KPG on top.
    always_comb begin
        sum_d  = xf_s ^ carry_s;
        cout_d = mf_s | (xf_s[WIDTH-1] & carry_s[WIDTH-1]);
        ovf_d  = carry_s[WIDTH-1] ^ cout_d;
    end

    // Result register; holds steady while downstream stalls.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_q <= 1'b0;
            sum_q       <= '0;
            cout_q      <= 1'b0;
            ovf_q       <= 1'b0;
        end else if (adv_s) begin
            out_valid_q <= vf_s;
            sum_q       <= sum_d;
            cout_q      <= cout_d;
            ovf_q       <= ovf_d;
        end
    end

    assign bus.out_valid = out_valid_q;
    assign bus.sum       = sum_q;
    assign bus.cout      = cout_q;
    assign bus.ovf       = ovf_q;
endmodule

// File: tb/tb_pipe_prefix_adder.sv
// Directed bench for pipe_prefix_adder: a WIDTH=16/PIPE=1 instance and a
// WIDTH=13/PIPE=0 instance, expected values hand-computed or from a golden sum.
module tb_pipe_prefix_adder;
    logic clk;
    logic rst_n;

    int n_cmp = 0;
    int n_err = 0;

    pipe_prefix_adder_if #(.WIDTH(16)) bus16 ();
    pipe_prefix_adder_if #(.WIDTH(13)) bus13 ();

    pipe_prefix_adder #(.WIDTH(16), .PIPE(1'b1)) u_dut16 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus16)
    );

    pipe_prefix_adder #(.WIDTH(13), .PIPE(1'b0)) u_dut13 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus13)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Send one beat on the 16-bit DUT (called at posedge+1 with in_ready=1)
    // and wait for its result; lat counts edges with the accept edge as 1.
    task automatic beat16(input logic [15:0] a_v, input logic [15:0] b_v,
                          input logic cin_v, input logic sub_v,
                          output logic [15:0] s, output logic co, output logic ov,
                          output int lat);
        bus16.a        = a_v;
        bus16.b        = b_v;
        bus16.cin      = cin_v;
        bus16.sub      = sub_v;
        bus16.in_valid = 1'b1;
        @(posedge clk); #1;
        bus16.in_valid = 1'b0;
        lat = 1;
        while (!bus16.out_valid && lat < 20) begin
            @(posedge clk); #1;
            lat++;
        end
        s  = bus16.sum;
        co = bus16.cout;
        ov = bus16.ovf;
    endtask

    logic [15:0] s16;
    logic        co16, ov16;
    int          lat;
    int          bi, ri, cyc, first, ir_low, seen;
    logic        acc;
    logic [17:0] held16;
    logic [12:0] ma, mb;
    logic [13:0] ext;
    logic        mc0;
    logic [14:0] exp_q[$];
    logic [14:0] held13;
    logic        stalled;
    int          sent, got;

    initial begin
        rst_n          = 1'b0;
        bus16.in_valid = 1'b0; bus16.a = 16'h0; bus16.b = 16'h0;
        bus16.cin      = 1'b0; bus16.sub = 1'b0; bus16.out_ready = 1'b1;
        bus13.in_valid = 1'b0; bus13.a = 13'h0; bus13.b = 13'h0;
        bus13.cin      = 1'b0; bus13.sub = 1'b0; bus13.out_ready = 1'b1;

        // reset state
        @(posedge clk); #1;
        @(posedge clk); #1;
        check_eq("rst_out_valid", 64'(bus16.out_valid), 64'd0);
        check_eq("rst_sum",       64'(bus16.sum),       64'd0);
        check_eq("rst_cout",      64'(bus16.cout),      64'd0);
        check_eq("rst_ovf",       64'(bus16.ovf),       64'd0);
        check_eq("rst_in_ready",  64'(bus16.in_ready),  64'd1);
        rst_n = 1'b1;
        @(posedge clk); #1;
        check_eq("post_rst_in_ready", 64'(bus16.in_ready), 64'd1);

        // carry wrap
        beat16(16'hFFFF, 16'h0001, 1'b0, 1'b0, s16, co16, ov16, lat);
        check_eq("wrap_lat",  64'(lat),  64'd6);
        check_eq("wrap_sum",  64'(s16),  64'h0000);
        check_eq("wrap_cout", 64'(co16), 64'd1);
        check_eq("wrap_ovf",  64'(ov16), 64'd0);

        // signed overflow
        beat16(16'h7FFF, 16'h0001, 1'b0, 1'b0, s16, co16, ov16, lat);
        check_eq("ovf_lat",  64'(lat),  64'd6);
        check_eq("ovf_sum",  64'(s16),  64'h8000);
        check_eq("ovf_cout", 64'(co16), 64'd0);
        check_eq("ovf_ovf",  64'(ov16), 64'd1);

        // subtract 5-7, cin ignored
        beat16(16'h0005, 16'h0007, 1'b1, 1'b1, s16, co16, ov16, lat);
        check_eq("sub_lat",  64'(lat),  64'd6);
        check_eq("sub_sum",  64'(s16),  64'hFFFE);
        check_eq("sub_cout", 64'(co16), 64'd0);
        check_eq("sub_ovf",  64'(ov16), 64'd0);

        // backpressure: 8 back-to-back beats, out_ready low 4 cycles
        @(posedge clk); #1;
        @(posedge clk); #1;
        bi = 0; ri = 0; cyc = 0; first = -1; ir_low = 0; held16 = '0;
        while (ri < 8 && cyc < 60) begin
            bus16.in_valid  = (bi < 8);
            bus16.a         = bi[15:0];
            bus16.b         = 16'(bi * 4096);
            bus16.cin       = 1'b0;
            bus16.sub       = 1'b0;
            bus16.out_ready = !(first >= 0 && cyc >= first + 3 && cyc <= first + 6);
            @(negedge clk);
            acc = bus16.in_valid & bus16.in_ready;
            if (!bus16.in_ready) ir_low++;
            if (first >= 0 && cyc >= first + 3 && cyc <= first + 6) begin
                check_eq("bp_in_ready", 64'(bus16.in_ready), 64'd0);
                if (cyc == first + 3) begin
                    held16 = {bus16.out_valid, bus16.cout, bus16.sum};
                end else begin
                    check_eq("bp_hold", 64'({bus16.out_valid, bus16.cout, bus16.sum}), 64'(held16));
                end
            end
            if (bus16.out_valid && bus16.out_ready) begin
                if (first < 0) first = cyc;
                check_eq("bp_sum", 64'(bus16.sum), 64'(16'(ri * 4097)));
                ri++;
            end
            @(posedge clk); #1;
            if (acc) bi++;
            cyc++;
        end
        bus16.in_valid  = 1'b0;
        bus16.out_ready = 1'b1;
        check_eq("bp_count",    64'(ri),     64'd8);
        check_eq("bp_low_cyc",  64'(ir_low), 64'd4);

        // reset mid-flight
        @(posedge clk); #1;
        @(posedge clk); #1;
        for (int i = 1; i <= 3; i++) begin
            bus16.a        = 16'(i);
            bus16.b        = 16'(i);
            bus16.in_valid = 1'b1;
            @(posedge clk); #1;
        end
        bus16.in_valid = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst_n = 1'b0;
        #1;
        check_eq("mid_rst_valid", 64'(bus16.out_valid), 64'd0);
        check_eq("mid_rst_sum",   64'(bus16.sum),       64'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        seen = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (bus16.out_valid) seen++;
        end
        check_eq("mid_rst_stale", 64'(seen), 64'd0);
        @(posedge clk); #1;
        beat16(16'h0003, 16'h0004, 1'b0, 1'b0, s16, co16, ov16, lat);
        check_eq("after_rst_lat", 64'(lat), 64'd6);
        check_eq("after_rst_sum", 64'(s16), 64'h0007);

        // combinational variant, directed
        bus13.a        = 13'h1FFF;
        bus13.b        = 13'h0000;
        bus13.cin      = 1'b1;
        bus13.sub      = 1'b0;
        bus13.in_valid = 1'b1;
        @(posedge clk); #1;
        bus13.in_valid = 1'b0;
        lat = 1;
        while (!bus13.out_valid && lat < 20) begin
            @(posedge clk); #1;
            lat++;
        end
        check_eq("w13_lat",  64'(lat),        64'd2);
        check_eq("w13_sum",  64'(bus13.sum),  64'h0000);
        check_eq("w13_cout", 64'(bus13.cout), 64'd1);
        check_eq("w13_ovf",  64'(bus13.ovf),  64'd0);
        @(posedge clk); #1;

        // combinational variant, random traffic against a golden sum
        sent = 0; got = 0; cyc = 0; stalled = 1'b0; held13 = '0;
        while ((sent < 10000 || got < sent) && cyc < 60000) begin
            bus13.in_valid  = (sent < 10000) && ($urandom_range(0, 3) != 0);
            bus13.a         = 13'($urandom);
            bus13.b         = 13'($urandom);
            bus13.cin       = 1'($urandom);
            bus13.sub       = 1'($urandom);
            bus13.out_ready = ($urandom_range(0, 3) != 0);
            @(negedge clk);
            if (stalled) begin
                check_eq("rnd_hold", 64'({bus13.out_valid, bus13.cout, bus13.ovf, bus13.sum}),
                         64'({1'b1, held13}));
            end
            if (bus13.in_valid && bus13.in_ready) begin
                ma  = bus13.a;
                mb  = bus13.sub ? ~bus13.b : bus13.b;
                mc0 = bus13.sub | bus13.cin;
                ext = {1'b0, ma} + {1'b0, mb} + 14'(mc0);
                exp_q.push_back({ext[13],
                                 (ma[12] == mb[12]) && (ext[12] != ma[12]),
                                 ext[12:0]});
                sent++;
            end
            if (bus13.out_valid && bus13.out_ready) begin
                check_eq("rnd_pending", 64'(exp_q.size() > 0), 64'd1);
                if (exp_q.size() > 0) begin
                    check_eq("rnd_result", 64'({bus13.cout, bus13.ovf, bus13.sum}),
                             64'(exp_q.pop_front()));
                end
                got++;
            end
            stalled = bus13.out_valid && !bus13.out_ready;
            held13  = {bus13.cout, bus13.ovf, bus13.sum};
            @(posedge clk); #1;
            cyc++;
        end
        bus13.in_valid = 1'b0;
        check_eq("rnd_count", 64'(got), 64'd10000);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
